// File: rtl/noc_resp_deframer.sv
// noc_resp_deframer: parses read/write response packets from the NOC byte
// stream, assembles payload into 64-bit words and queues completed responses
// in a small show-ahead FIFO. Truncated packets raise err_trunc. Responses
// that find the FIFO full raise err_ovf. In both cases the packet is dropped.
module noc_resp_deframer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        noc_from_dev_ctl,
    input  logic [7:0]  noc_from_dev_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_is_read,
    output logic [7:0]  rsp_tag,
    output logic [1:0]  rsp_size,
    output logic [63:0] rsp_data,
    output logic        err_trunc,
    output logic        err_ovf
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic        is_read;
        logic [7:0]  tag;
        logic [1:0]  size;
        logic [63:0] data;
    } rsp_t;

    typedef enum logic [1:0] {S_IDLE, S_TAG, S_BODY, S_SKIP} state_t;

    state_t          state, state_nxt, hdr_state;
    logic [2:0]      hdr_cmd;
    logic            hdr_rsp;
    logic            is_read_q;
    logic [1:0]      size_q;
    logic [7:0]      tag_q;
    logic [7:0][7:0] asm_q, asm_nxt;
    logic [2:0]      count_q;
    logic [3:0]      lanes;
    logic            last_byte;
    logic            hdr_latch, tag_latch, body_wr, push, trunc;

    rsp_t            mem [DEPTH];
    rsp_t            entry, head;
    logic [AW:0]     wr_ptr, rd_ptr;
    logic            empty, full, pop, push_ok;

    assign hdr_cmd   = noc_from_dev_data[7:5];
    assign hdr_rsp   = (hdr_cmd == 3'd3) || (hdr_cmd == 3'd4);
    // Writes latch size 0, so the lane formula also yields a one-byte body.
    assign lanes     = 4'd1 << size_q;
    assign last_byte = ({1'b0, count_q} == (lanes - 4'd1));

    // Where any header byte sends the parser, whatever state it is in
    always_comb begin
        hdr_state = S_SKIP;
        if (hdr_cmd == 3'd0) hdr_state = S_IDLE;
        else if (hdr_rsp)    hdr_state = S_TAG;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state: any ctl=1 byte is decoded as a header, even mid-packet
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_SKIP: if (noc_from_dev_ctl) state_nxt = hdr_state;
            S_TAG:          state_nxt = noc_from_dev_ctl ? hdr_state : S_BODY;
            S_BODY: begin
                if (noc_from_dev_ctl) state_nxt = hdr_state;
                else if (last_byte)   state_nxt = S_IDLE;
            end
            default:        state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: datapath strobes, push and truncation detect
    always_comb begin
        hdr_latch = noc_from_dev_ctl && hdr_rsp;
        tag_latch = (state == S_TAG)  && !noc_from_dev_ctl;
        body_wr   = (state == S_BODY) && !noc_from_dev_ctl;
        push      = body_wr && last_byte;
        trunc     = noc_from_dev_ctl && ((state == S_TAG) || (state == S_BODY));
    end

    // Entry built from the assembly register plus the byte arriving now,
    // so the push happens on the edge that samples the last byte
    always_comb begin
        asm_nxt          = asm_q;
        asm_nxt[count_q] = noc_from_dev_data;
        entry.is_read    = is_read_q;
        entry.tag        = tag_q;
        entry.size       = size_q;
        entry.data       = asm_nxt;
    end

    // Packet datapath: header fields, tag, payload assembly, byte count
    always_ff @(posedge clk) begin
        if (reset) begin
            is_read_q <= 1'b0;
            size_q    <= '0;
            tag_q     <= '0;
            asm_q     <= '0;
            count_q   <= '0;
            err_trunc <= 1'b0;
        end else begin
            err_trunc <= trunc;
            if (hdr_latch) begin
                is_read_q <= (hdr_cmd == 3'd3);
                size_q    <= (hdr_cmd == 3'd3) ? noc_from_dev_data[4:3] : 2'd0;
            end
            if (tag_latch) begin
                tag_q   <= noc_from_dev_data;
                asm_q   <= '0;
                count_q <= '0;
            end
            if (body_wr) begin
                asm_q   <= asm_nxt;
                count_q <= count_q + 3'd1;
            end
        end
    end

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = rsp_valid && rsp_ready;
    // A full FIFO still takes a push when the head leaves on the same edge
    assign push_ok = push && (!full || pop);

    // FIFO storage, no reset needed: outputs are gated by rsp_valid
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= entry;
    end

    // FIFO pointers and overflow pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            err_ovf <= 1'b0;
        end else begin
            err_ovf <= push && full && !pop;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Show-ahead head, zeroed while empty
    always_comb begin
        head        = mem[rd_ptr[AW-1:0]];
        rsp_valid   = !empty;
        rsp_is_read = rsp_valid ? head.is_read : 1'b0;
        rsp_tag     = rsp_valid ? head.tag     : 8'h00;
        rsp_size    = rsp_valid ? head.size    : 2'd0;
        rsp_data    = rsp_valid ? head.data    : 64'h0;
    end

endmodule

// File: tb/tb_noc_resp_deframer.sv
// Bench for noc_resp_deframer: a packet-level model (a byte queue per packet
// plus a response queue) is compared with the DUT on every falling edge.
// Literal checks at key points pin the model to hand-computed values.
module tb_noc_resp_deframer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ctl = 1'b1;
    logic [7:0]  data = 8'h00;
    logic        rsp_ready = 1'b0;
    logic        rsp_valid, rsp_is_read, err_trunc, err_ovf;
    logic [7:0]  rsp_tag;
    logic [1:0]  rsp_size;
    logic [63:0] rsp_data;

    always #5 clk = ~clk;

    noc_resp_deframer #(.DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .noc_from_dev_ctl  (ctl),
        .noc_from_dev_data (data),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_is_read       (rsp_is_read),
        .rsp_tag           (rsp_tag),
        .rsp_size          (rsp_size),
        .rsp_data          (rsp_data),
        .err_trunc         (err_trunc),
        .err_ovf           (err_ovf)
    );

    typedef struct {
        bit        is_read;
        bit [7:0]  tag;
        bit [1:0]  size;
        bit [63:0] data;
    } exp_t;

    exp_t         q[$];
    byte unsigned pb[$];
    bit           in_pkt, cur_read;
    bit [1:0]     cur_size;
    int           need;
    bit           exp_trunc, exp_ovf;
    bit           chk_en = 1'b0;
    int           checks = 0;
    int           errors = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endfunction

    // Packet-level model: collect the bytes of the current packet until its
    // length (tag + payload) is reached, then queue the response.
    task automatic model_step();
        exp_t e;
        bit   pushed;
        bit   pop;
        exp_trunc = 1'b0;
        exp_ovf   = 1'b0;
        pushed    = 1'b0;
        e         = '{default: 0};
        if (reset) begin
            q.delete();
            pb.delete();
            in_pkt = 1'b0;
            return;
        end
        pop = (q.size() > 0) && rsp_ready;
        if (ctl) begin
            exp_trunc = in_pkt;
            in_pkt    = (data[7:5] == 3'd3) || (data[7:5] == 3'd4);
            cur_read  = (data[7:5] == 3'd3);
            cur_size  = cur_read ? data[4:3] : 2'd0;
            need      = 1 + (cur_read ? (1 << cur_size) : 1);
            pb.delete();
        end else if (in_pkt) begin
            pb.push_back(data);
            if (pb.size() == need) begin
                e.is_read = cur_read;
                e.tag     = pb[0];
                e.size    = cur_size;
                for (int i = 1; i < need; i++)
                    e.data |= 64'(pb[i]) << (8 * (i - 1));
                pushed = 1'b1;
                in_pkt = 1'b0;
            end
        end
        if (pop) void'(q.pop_front());
        if (pushed) begin
            if (q.size() < DEPTH) q.push_back(e);
            else                  exp_ovf = 1'b1;
        end
    endtask

    // One stream byte: drive after a falling edge, model at the rising edge
    task automatic cyc(input bit c, input bit [7:0] d);
        ctl  = c;
        data = d;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // Every-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("rsp_valid", rsp_valid, 64'(q.size() > 0));
                chk("err_trunc", err_trunc, 64'(exp_trunc));
                chk("err_ovf",   err_ovf,   64'(exp_ovf));
                if (q.size() > 0) begin
                    chk("rsp_is_read", rsp_is_read, 64'(q[0].is_read));
                    chk("rsp_tag",     rsp_tag,     64'(q[0].tag));
                    chk("rsp_size",    rsp_size,    64'(q[0].size));
                    chk("rsp_data",    rsp_data,    q[0].data);
                end
            end
        end
    end

    initial begin
        @(negedge clk);
        reset = 1'b1;
        cyc(1'b1, 8'h00);
        chk_en = 1'b1;
        cyc(1'b1, 8'h00);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_trunc", err_trunc, 0);
        chk("rst_ovf",   err_ovf,   0);
        chk("rst_tag",   rsp_tag,   0);
        chk("rst_data",  rsp_data,  0);
        reset = 1'b0;

        // Read size 2, tag 5A, payload 11 22 33 44
        cyc(1'b1, 8'h70);
        cyc(1'b0, 8'h5A);
        cyc(1'b0, 8'h11);
        cyc(1'b0, 8'h22);
        cyc(1'b0, 8'h33);
        chk("rd_valid_before", rsp_valid, 0);
        cyc(1'b0, 8'h44);
        chk("rd_valid",   rsp_valid,   1);
        chk("rd_is_read", rsp_is_read, 1);
        chk("rd_tag",     rsp_tag,     64'h5A);
        chk("rd_size",    rsp_size,    2);
        chk("rd_data",    rsp_data,    64'h0000_0000_4433_2211);
        rsp_ready = 1'b1;
        cyc(1'b1, 8'h00);
        chk("rd_popped", rsp_valid, 0);

        // Write response, tag 07, status 01, consumer ready
        cyc(1'b1, 8'h80);
        cyc(1'b0, 8'h07);
        cyc(1'b0, 8'h01);
        chk("wr_valid",   rsp_valid,   1);
        chk("wr_is_read", rsp_is_read, 0);
        chk("wr_tag",     rsp_tag,     64'h07);
        chk("wr_size",    rsp_size,    0);
        chk("wr_data",    rsp_data,    64'h01);
        cyc(1'b1, 8'h00);
        chk("wr_empty", rsp_valid, 0);
        rsp_ready = 1'b0;

        // Read size 3 truncated at payload byte 5 by a write header
        cyc(1'b1, 8'h78);
        cyc(1'b0, 8'hA1);
        for (int i = 1; i <= 4; i++) cyc(1'b0, 8'(i));
        cyc(1'b1, 8'h80);
        chk("tr_pulse", err_trunc, 1);
        chk("tr_none",  rsp_valid, 0);
        cyc(1'b0, 8'h33);
        chk("tr_pulse_end", err_trunc, 0);
        cyc(1'b0, 8'h55);
        chk("tr_new_tag",  rsp_tag,  64'h33);
        chk("tr_new_data", rsp_data, 64'h55);
        rsp_ready = 1'b1;
        cyc(1'b1, 8'h00);
        rsp_ready = 1'b0;

        // DEPTH+1 writes with consumer stalled: fifth is dropped
        for (int t = 0; t <= 4; t++) begin
            cyc(1'b1, 8'h80);
            cyc(1'b0, 8'(t));
            cyc(1'b0, 8'(8'hE0 + t));
        end
        chk("ovf_pulse", err_ovf, 1);
        cyc(1'b1, 8'h00);
        chk("ovf_pulse_end", err_ovf, 0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("ovf_drain_tag", rsp_tag, 64'(i));
            cyc(1'b1, 8'h00);
        end
        chk("ovf_drained", rsp_valid, 0);
        rsp_ready = 1'b0;

        // Full FIFO, push and pop on the same edge
        for (int t = 0; t < 4; t++) begin
            cyc(1'b1, 8'h80);
            cyc(1'b0, 8'(8'h10 + t));
            cyc(1'b0, 8'hF0);
        end
        cyc(1'b1, 8'h80);
        cyc(1'b0, 8'h14);
        rsp_ready = 1'b1;
        cyc(1'b0, 8'hF4);
        rsp_ready = 1'b0;
        chk("pp_no_ovf", err_ovf, 0);
        chk("pp_head",   rsp_tag, 64'h11);
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("pp_drain_tag", rsp_tag, 64'(8'h11 + i));
            cyc(1'b1, 8'h00);
        end
        chk("pp_drained", rsp_valid, 0);
        rsp_ready = 1'b0;

        // Foreign cmd 5 with body, idle headers, then read size 0
        cyc(1'b1, 8'hA0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 8'(8'hC0 + i));
        cyc(1'b1, 8'h00);
        cyc(1'b1, 8'h00);
        chk("fg_none", rsp_valid, 0);
        cyc(1'b1, 8'h60);
        cyc(1'b0, 8'h9C);
        cyc(1'b0, 8'hAB);
        chk("fg_valid", rsp_valid, 1);
        chk("fg_tag",   rsp_tag,   64'h9C);
        chk("fg_size",  rsp_size,  0);
        chk("fg_data",  rsp_data,  64'hAB);
        rsp_ready = 1'b1;
        cyc(1'b1, 8'h00);
        chk("fg_single", rsp_valid, 0);
        rsp_ready = 1'b0;

        // Reset mid-packet, stray body byte, then back-to-back writes
        cyc(1'b1, 8'h70);
        cyc(1'b0, 8'h66);
        cyc(1'b0, 8'h01);
        reset = 1'b1;
        cyc(1'b1, 8'h00);
        reset = 1'b0;
        chk("rm_no_trunc", err_trunc, 0);
        cyc(1'b0, 8'h77);
        cyc(1'b1, 8'h80);
        cyc(1'b0, 8'h03);
        cyc(1'b0, 8'h04);
        cyc(1'b1, 8'h80);
        cyc(1'b0, 8'h05);
        cyc(1'b0, 8'h06);
        chk("b2b_head", rsp_tag, 64'h03);
        rsp_ready = 1'b1;
        cyc(1'b1, 8'h00);
        chk("b2b_second", rsp_tag, 64'h05);
        cyc(1'b1, 8'h00);
        chk("b2b_empty", rsp_valid, 0);
        rsp_ready = 1'b0;
        cyc(1'b1, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
